// File: rtl/simple_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simple_axi_write_arbiter
// Brief    : Round-robin N:1 arbiter for a simple write port; owner held to m_wlast.
// Revision : 1.0 - initial release
// ============================================================================
module simple_axi_write_arbiter #(
  parameter int N_REQ      = 2,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               s_wvalid,
  output logic [N_REQ-1:0]               s_wready,
  input  logic [N_REQ*AXI_ADDR_W-1:0]    s_waddr,
  input  logic [N_REQ*AXI_DATA_W-1:0]    s_wdata,
  input  logic [N_REQ*AXI_DATA_W/8-1:0]  s_wstrb,
  input  logic [N_REQ*LEN_W-1:0]         s_wlen,
  output logic [N_REQ-1:0]               s_wlast,
  output logic                           m_wvalid,
  input  logic                           m_wready,
  output logic [AXI_ADDR_W-1:0]          m_waddr,
  output logic [AXI_DATA_W-1:0]          m_wdata,
  output logic [AXI_DATA_W/8-1:0]        m_wstrb,
  output logic [LEN_W-1:0]               m_wlen,
  input  logic                           m_wlast,
  output logic [N_REQ-1:0]               grant,
  output logic                           busy
);

  localparam int C_IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int C_STRB_W = AXI_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ZLEN = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [N_REQ-1:0]       r_grant, w_grant_nxt;
  logic [C_IDX_W-1:0]     r_gidx, w_gidx_nxt;
  logic [C_IDX_W-1:0]     r_rr_ptr, w_ptr_nxt;
  logic [AXI_ADDR_W-1:0]  r_waddr, w_waddr_nxt;
  logic [LEN_W-1:0]       r_wlen, w_wlen_nxt;

  logic [AXI_ADDR_W-1:0]  w_addr_arr [N_REQ];
  logic [AXI_DATA_W-1:0]  w_data_arr [N_REQ];
  logic [C_STRB_W-1:0]    w_strb_arr [N_REQ];
  logic [LEN_W-1:0]       w_len_arr  [N_REQ];

  logic                   w_found;
  logic [C_IDX_W-1:0]     w_win;
  logic [C_IDX_W-1:0]     w_cand;
  logic [C_IDX_W-1:0]     w_ptr_inc;
  int                     w_j;

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign w_addr_arr[i] = s_waddr[i*AXI_ADDR_W +: AXI_ADDR_W];
      assign w_data_arr[i] = s_wdata[i*AXI_DATA_W +: AXI_DATA_W];
      assign w_strb_arr[i] = s_wstrb[i*C_STRB_W +: C_STRB_W];
      assign w_len_arr[i]  = s_wlen[i*LEN_W +: LEN_W];
    end
  endgenerate

  // Scan from the pointer upward, wrapping, and keep the first valid requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(r_rr_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_cand = C_IDX_W'(w_j);
      if (!w_found && s_wvalid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_ptr_inc = (r_gidx == C_IDX_W'(N_REQ - 1)) ? '0 : r_gidx + C_IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_rr_ptr;
    w_waddr_nxt = r_waddr;
    w_wlen_nxt  = r_wlen;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt        = '0;
          w_grant_nxt[w_win] = 1'b1;
          w_gidx_nxt         = w_win;
          w_waddr_nxt        = w_addr_arr[w_win];
          w_wlen_nxt         = w_len_arr[w_win];
          w_state_nxt        = (w_len_arr[w_win] == '0) ? ST_ZLEN : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (m_wlast) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      ST_ZLEN: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_ptr_nxt   = w_ptr_inc;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_gidx   <= '0;
      r_rr_ptr <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_gidx   <= w_gidx_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wlen   <= w_wlen_nxt;
    end
  end

  // Data path is a pure mux on the owner; m_wlast only reaches a requester in BUSY.
  always_comb begin
    m_wvalid = 1'b0;
    m_wdata  = '0;
    m_wstrb  = '0;
    s_wready = '0;
    s_wlast  = '0;
    if (r_state == ST_BUSY) begin
      m_wvalid         = s_wvalid[r_gidx];
      m_wdata          = w_data_arr[r_gidx];
      m_wstrb          = w_strb_arr[r_gidx];
      s_wready[r_gidx] = m_wready;
      s_wlast[r_gidx]  = m_wlast;
    end else if (r_state == ST_ZLEN) begin
      s_wlast[r_gidx]  = 1'b1;
    end
  end

  assign grant   = r_grant;
  assign busy    = (r_state != ST_IDLE);
  assign m_waddr = r_waddr;
  assign m_wlen  = r_wlen;

endmodule
`default_nettype wire

// File: tb/tb_simple_axi_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_axi_write_arbiter
// Brief    : Directed vector table plus hand sequences for stall and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_axi_write_arbiter;

  localparam int C_N  = 2;
  localparam int C_AW = 32;
  localparam int C_DW = 32;
  localparam int C_LW = 8;
  localparam int C_NV = 22;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [C_N-1:0]       s_wvalid = '0;
  logic [C_N-1:0]       s_wready;
  logic [C_N*C_AW-1:0]  s_waddr;
  logic [C_N*C_DW-1:0]  s_wdata;
  logic [C_N*C_DW/8-1:0] s_wstrb;
  logic [C_N*C_LW-1:0]  s_wlen;
  logic [C_N-1:0]       s_wlast;
  logic                 m_wvalid;
  logic                 m_wready = 1'b0;
  logic [C_AW-1:0]      m_waddr;
  logic [C_DW-1:0]      m_wdata;
  logic [C_DW/8-1:0]    m_wstrb;
  logic [C_LW-1:0]      m_wlen;
  logic                 m_wlast = 1'b0;
  logic [C_N-1:0]       grant;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  simple_axi_write_arbiter #(
    .N_REQ(C_N), .AXI_ADDR_W(C_AW), .AXI_DATA_W(C_DW), .LEN_W(C_LW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_waddr(s_waddr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlen(s_wlen), .s_wlast(s_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_waddr(m_waddr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlen(m_wlen), .m_wlast(m_wlast),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  wv;
    logic        wr;
    logic        wl;
    logic [7:0]  len0;
    logic [1:0]  e_grant;
    logic        e_busy;
    logic        e_mv;
    logic [1:0]  e_sr;
    logic [1:0]  e_sl;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [C_NV];

  localparam logic [31:0] C_DA = 32'hAAAA_0000;
  localparam logic [31:0] C_DB = 32'hBBBB_1111;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " grant"}, 64'(grant), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " m_wvalid"}, 64'(m_wvalid), 64'd0);
    chk({tag, " s_wready"}, 64'(s_wready), 64'd0);
    chk({tag, " s_wlast"}, 64'(s_wlast), 64'd0);
  endtask

  logic [6:0] stall_pat;
  int         hs;

  initial begin
    s_waddr = {32'h0000_0100, 32'h0000_0200};
    s_wdata = {C_DB, C_DA};
    s_wstrb = {4'h3, 4'hF};
    s_wlen  = {8'd16, 8'd4};

    //            rst wv    wr    wl    len0   grant  busy  mv    sr     sl     data
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[2]  = '{1'b1, 2'b10, 1'b1, 1'b0, 8'd4, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, C_DB};
    vecs[3]  = '{1'b1, 2'b10, 1'b1, 1'b0, 8'd4, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, C_DB};
    vecs[4]  = '{1'b1, 2'b10, 1'b1, 1'b0, 8'd4, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, C_DB};
    vecs[5]  = '{1'b1, 2'b10, 1'b1, 1'b1, 8'd4, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, C_DB};
    vecs[6]  = '{1'b1, 2'b00, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 2'b00, 1'b1, 1'b1, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[8]  = '{1'b1, 2'b11, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[9]  = '{1'b1, 2'b11, 1'b1, 1'b1, 8'd4, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, C_DA};
    vecs[10] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[11] = '{1'b1, 2'b11, 1'b1, 1'b1, 8'd4, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, C_DB};
    vecs[12] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[13] = '{1'b1, 2'b11, 1'b1, 1'b1, 8'd4, 2'b01, 1'b1, 1'b1, 2'b01, 2'b01, C_DA};
    vecs[14] = '{1'b1, 2'b00, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[15] = '{1'b1, 2'b01, 1'b0, 1'b0, 8'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[16] = '{1'b1, 2'b01, 1'b1, 1'b0, 8'd0, 2'b01, 1'b1, 1'b0, 2'b00, 2'b01, 32'h0};
    vecs[17] = '{1'b1, 2'b00, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[18] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};
    vecs[19] = '{1'b1, 2'b11, 1'b0, 1'b0, 8'd4, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, C_DB};
    vecs[20] = '{1'b1, 2'b11, 1'b1, 1'b1, 8'd4, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, C_DB};
    vecs[21] = '{1'b1, 2'b00, 1'b0, 1'b0, 8'd4, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0};

    for (int i = 0; i < C_NV; i++) begin
      @(negedge clk);
      rst      = vecs[i].rst_n;
      s_wvalid = vecs[i].wv;
      m_wready = vecs[i].wr;
      m_wlast  = vecs[i].wl;
      s_wlen   = {8'd16, vecs[i].len0};
      #1;
      chk($sformatf("v%0d grant", i), 64'(grant), 64'(vecs[i].e_grant));
      chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d m_wvalid", i), 64'(m_wvalid), 64'(vecs[i].e_mv));
      chk($sformatf("v%0d s_wready", i), 64'(s_wready), 64'(vecs[i].e_sr));
      chk($sformatf("v%0d s_wlast", i), 64'(s_wlast), 64'(vecs[i].e_sl));
      chk($sformatf("v%0d m_wdata", i), 64'(m_wdata), 64'(vecs[i].e_data));
    end

    // Stall: requester 0 drops valid for 3 cycles while requester 1 waits.
    @(negedge clk);
    s_wvalid = 2'b11;
    s_wlen   = {8'd16, 8'd16};
    m_wready = 1'b1;
    m_wlast  = 1'b0;
    #1;
    chk_idle("stall pre");
    stall_pat = 7'b1100011;
    hs = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      s_wvalid = {1'b1, stall_pat[6-c]};
      s_wdata  = {C_DB, 32'h0000_1000 + 32'(c)};
      m_wlast  = (c == 6);
      #1;
      chk($sformatf("stall c%0d grant", c), 64'(grant), 64'd1);
      chk($sformatf("stall c%0d m_wvalid", c), 64'(m_wvalid), 64'(stall_pat[6-c]));
      chk($sformatf("stall c%0d s_wready", c), 64'(s_wready), 64'd1);
      chk($sformatf("stall c%0d m_wdata", c), 64'(m_wdata), 64'(32'h0000_1000 + 32'(c)));
      chk($sformatf("stall c%0d s_wlast", c), 64'(s_wlast), (c == 6) ? 64'd1 : 64'd0);
      if (m_wvalid && m_wready) hs++;
    end
    chk("stall m_waddr", 64'(m_waddr), 64'h200);
    chk("stall m_wlen", 64'(m_wlen), 64'd16);
    chk("stall m_wstrb", 64'(m_wstrb), 64'hF);
    chk("stall handshakes", 64'(hs), 64'd4);

    // Idle gap, then requester 1 wins because the pointer moved past 0.
    @(negedge clk);
    s_wvalid = 2'b11;
    m_wlast  = 1'b0;
    #1;
    chk_idle("gap");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("r1 c%0d grant", c), 64'(grant), 64'd2);
      chk($sformatf("r1 c%0d m_waddr", c), 64'(m_waddr), 64'h100);
      chk($sformatf("r1 c%0d m_wlen", c), 64'(m_wlen), 64'd16);
      chk($sformatf("r1 c%0d m_wdata", c), 64'(m_wdata), 64'(C_DB));
      chk($sformatf("r1 c%0d m_wstrb", c), 64'(m_wstrb), 64'h3);
      chk($sformatf("r1 c%0d s_wready", c), 64'(s_wready), 64'd2);
    end

    // Reset mid-transfer: outputs drop at once, no s_wlast even with m_wlast high.
    @(negedge clk);
    rst     = 1'b0;
    m_wlast = 1'b1;
    #1;
    chk_idle("rst");
    chk("rst m_waddr", 64'(m_waddr), 64'd0);
    chk("rst m_wlen", 64'(m_wlen), 64'd0);
    chk("rst m_wdata", 64'(m_wdata), 64'd0);
    @(negedge clk);
    rst     = 1'b1;
    m_wlast = 1'b0;
    #1;
    chk_idle("post rst");
    @(negedge clk);
    #1;
    chk("post rst grant", 64'(grant), 64'd1);
    chk("post rst m_waddr", 64'(m_waddr), 64'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
